// File: rtl/line_draw_arbiter.sv
// Arbitrates one line_drawer + framebuffer write port between the screen clearer (req[0]) and animator (req[1]).
// Optional macro LINE_ARB_ROUND_ROBIN_EN: alternating priority instead of fixed CLR > ANI.
module line_draw_arbiter #(
    parameter int RST_CYCLES  = 5,
    parameter int TAIL_CYCLES = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [9:0] clr_x0,
    input  logic [9:0] clr_x1,
    input  logic [8:0] clr_y0,
    input  logic [8:0] clr_y1,
    input  logic       clr_color,
    input  logic [9:0] ani_x0,
    input  logic [9:0] ani_x1,
    input  logic [8:0] ani_y0,
    input  logic [8:0] ani_y1,
    input  logic       ani_color,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic       drw_reset,
    output logic [9:0] drw_x0,
    output logic [9:0] drw_x1,
    output logic [8:0] drw_y0,
    output logic [8:0] drw_y1,
    output logic       pixel_color,
    output logic       pixel_write
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'((TAIL_CYCLES > 0) ? TAIL_CYCLES - 1 : 0);
    localparam bit               HAS_TAIL  = (TAIL_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RST, S_DRAW, S_TAIL, S_DONE
    } state_t;

    state_t           r_state;
    logic             r_sel;      // 0 = CLR, 1 = ANI
    logic [CNT_W-1:0] r_cnt;
    logic             w_pick_ani;
    logic             w_at_end;

`ifdef LINE_ARB_ROUND_ROBIN_EN
    logic r_rr;
    // r_rr=1 favours ANI; otherwise CLR wins ties
    assign w_pick_ani = r_rr ? req[1] : (req[1] & ~req[0]);
`else
    assign w_pick_ani = req[1] & ~req[0];
`endif

    assign w_at_end = (x == drw_x1) && (y == drw_y1);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_cnt       <= '0;
            gnt         <= 2'b00;
            done        <= 2'b00;
            busy        <= 1'b0;
            drw_reset   <= 1'b1;
            pixel_write <= 1'b0;
            pixel_color <= 1'b0;
            drw_x0      <= '0;
            drw_x1      <= '0;
            drw_y0      <= '0;
            drw_y1      <= '0;
`ifdef LINE_ARB_ROUND_ROBIN_EN
            r_rr        <= 1'b0;
`endif
        end else begin
            done <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    drw_reset   <= 1'b1;
                    pixel_write <= 1'b0;
                    if (req != 2'b00) begin
                        r_sel   <= w_pick_ani;
                        gnt     <= w_pick_ani ? 2'b10 : 2'b01;
                        busy    <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    drw_x0      <= r_sel ? ani_x0    : clr_x0;
                    drw_x1      <= r_sel ? ani_x1    : clr_x1;
                    drw_y0      <= r_sel ? ani_y0    : clr_y0;
                    drw_y1      <= r_sel ? ani_y1    : clr_y1;
                    pixel_color <= r_sel ? ani_color : clr_color;
                    r_cnt       <= '0;
                    r_state     <= S_RST;
                end
                S_RST: begin
                    if (r_cnt == RST_LAST) begin
                        drw_reset   <= 1'b0;
                        pixel_write <= 1'b1;
                        r_state     <= S_DRAW;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DRAW: begin
                    // endpoint pixel is written this cycle; tail flushes the drawer pipeline
                    if (w_at_end) begin
                        if (HAS_TAIL) begin
                            r_cnt   <= '0;
                            r_state <= S_TAIL;
                        end else begin
                            pixel_write <= 1'b0;
                            drw_reset   <= 1'b1;
                            done        <= gnt;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_TAIL: begin
                    if (r_cnt == TAIL_LAST) begin
                        pixel_write <= 1'b0;
                        drw_reset   <= 1'b1;
                        done        <= gnt;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    gnt     <= 2'b00;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
`ifdef LINE_ARB_ROUND_ROBIN_EN
                    r_rr    <= ~r_sel;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_draw_arbiter.sv
// Directed bench for line_draw_arbiter with a simple one-step-per-cycle line drawer model.
module tb_line_draw_arbiter;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [1:0] req      = 2'b00;
    logic [9:0] clr_x0 = '0, clr_x1 = '0, ani_x0 = '0, ani_x1 = '0;
    logic [8:0] clr_y0 = '0, clr_y1 = '0, ani_y0 = '0, ani_y1 = '0;
    logic       clr_color = 1'b0, ani_color = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic [1:0] gnt, done;
    logic       busy, drw_reset, pixel_color, pixel_write;
    logic [9:0] drw_x0, drw_x1;
    logic [8:0] drw_y0, drw_y1;

    int ncmp = 0;
    int nerr = 0;

    line_draw_arbiter #(.RST_CYCLES(5), .TAIL_CYCLES(2)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .req(req),
        .clr_x0(clr_x0), .clr_x1(clr_x1), .clr_y0(clr_y0), .clr_y1(clr_y1), .clr_color(clr_color),
        .ani_x0(ani_x0), .ani_x1(ani_x1), .ani_y0(ani_y0), .ani_y1(ani_y1), .ani_color(ani_color),
        .gnt(gnt), .done(done), .busy(busy), .x(x), .y(y),
        .drw_reset(drw_reset), .drw_x0(drw_x0), .drw_x1(drw_x1), .drw_y0(drw_y0), .drw_y1(drw_y1),
        .pixel_color(pixel_color), .pixel_write(pixel_write)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Drawer model: parks on (x0,y0) while in reset, then steps one unit per cycle toward (x1,y1)
    always @(posedge CLOCK_50) begin
        if (drw_reset) begin
            x <= drw_x0;
            y <= drw_y0;
        end else begin
            if (x < drw_x1) x <= x + 1'b1; else if (x > drw_x1) x <= x - 1'b1;
            if (y < drw_y1) y <= y + 1'b1; else if (y > drw_y1) y <= y - 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Follows one grant from start to the IDLE cycle after DONE.
    // lat_g/lat_w: edges from call to first busy / first write; nrst: drw_reset cycles after LOAD before first write.
    task automatic run_op(input bit drop, output logic [1:0] g, output int lat_g, output int lat_w,
                          output int nrst, output int nwr, output int ndone, output logic [1:0] dbits,
                          output bit saw11, output int gap);
        int  t = 0;
        int  done_t = -1;
        bit  started = 1'b0;
        g = 2'b00; lat_g = -1; lat_w = -1; nrst = 0; nwr = 0; ndone = 0;
        dbits = 2'b00; saw11 = 1'b0; gap = -1;
        while (t < 2000) begin
            cyc();
            t++;
            if (gnt == 2'b11) saw11 = 1'b1;
            if (busy && !started) begin
                started = 1'b1;
                g = gnt;
                lat_g = t;
            end
            if (started) begin
                if (pixel_write) begin
                    nwr++;
                    if (lat_w < 0) lat_w = t;
                end else if (drw_reset && busy && lat_w < 0 && t > lat_g) begin
                    nrst++;
                end
                if (done != 2'b00) begin
                    ndone++;
                    dbits |= done;
                    done_t = t;
                    if (drop) req = req & ~done;
                end
                if (!busy) begin
                    gap = t - done_t;
                    break;
                end
            end
        end
        chk("op_completed", {31'b0, started && !busy}, 32'd1);
    endtask

    logic [1:0] g;
    logic [1:0] dbits;
    int         lat_g, lat_w, nrst, nwr, ndone, gap;
    bit         saw11;
    bit         seen;
    logic [1:0] order [4];

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_gnt", {30'b0, gnt}, 0);
        chk("rst_done", {30'b0, done}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_drw_reset", {31'b0, drw_reset}, 1);
        chk("rst_pixel_write", {31'b0, pixel_write}, 0);
        chk("rst_pixel_color", {31'b0, pixel_color}, 0);
        chk("rst_drw_x1", {22'b0, drw_x1}, 0);
        chk("rst_drw_y1", {23'b0, drw_y1}, 0);
        reset = 1'b0;
        cyc();

        // Single ANI request (30,100)->(100,30): 71 draw cycles + 2 tail
        ani_x0 = 10'd30; ani_y0 = 9'd100; ani_x1 = 10'd100; ani_y1 = 9'd30; ani_color = 1'b1;
        req = 2'b10;
        run_op(1'b1, g, lat_g, lat_w, nrst, nwr, ndone, dbits, saw11, gap);
        chk("ani_gnt", {30'b0, g}, 32'h2);
        chk("ani_gnt_latency", lat_g, 1);
        chk("ani_rst_hold", nrst, 5);
        chk("ani_first_write", lat_w, 7);
        chk("ani_writes", nwr, 73);
        chk("ani_done_count", ndone, 1);
        chk("ani_done_bits", {30'b0, dbits}, 32'h2);
        chk("ani_busy_after_done", gap, 1);
        chk("ani_pixel_color", {31'b0, pixel_color}, 1);

        // Simultaneous requests: CLR column first, then ANI right after
        clr_x0 = 10'd7; clr_y0 = 9'd0; clr_x1 = 10'd7; clr_y1 = 9'd479; clr_color = 1'b0;
        req = 2'b11;
        run_op(1'b1, g, lat_g, lat_w, nrst, nwr, ndone, dbits, saw11, gap);
        chk("sim_clr_gnt", {30'b0, g}, 32'h1);
        chk("sim_clr_writes", nwr, 482);
        chk("sim_clr_done", {30'b0, dbits}, 32'h1);
        chk("sim_clr_done_count", ndone, 1);
        chk("sim_clr_no_gnt11", {31'b0, saw11}, 0);
        chk("sim_clr_pixel_color", {31'b0, pixel_color}, 0);
        run_op(1'b1, g, lat_g, lat_w, nrst, nwr, ndone, dbits, saw11, gap);
        chk("sim_ani_gnt", {30'b0, g}, 32'h2);
        chk("sim_ani_gnt_latency", lat_g, 1);
        chk("sim_ani_done", {30'b0, dbits}, 32'h2);
        chk("sim_ani_done_count", ndone, 1);
        chk("sim_ani_no_gnt11", {31'b0, saw11}, 0);

        // Continuous dual requests for four operations
        clr_x0 = 10'd0; clr_y0 = 9'd0; clr_x1 = 10'd3; clr_y1 = 9'd0;
        ani_x0 = 10'd5; ani_y0 = 9'd5; ani_x1 = 10'd5; ani_y1 = 9'd8;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, g, lat_g, lat_w, nrst, nwr, ndone, dbits, saw11, gap);
            order[i] = g;
        end
        req = 2'b00;
`ifdef LINE_ARB_ROUND_ROBIN_EN
        chk("rr_order0", {30'b0, order[0]}, 32'h1);
        chk("rr_order1", {30'b0, order[1]}, 32'h2);
        chk("rr_order2", {30'b0, order[2]}, 32'h1);
        chk("rr_order3", {30'b0, order[3]}, 32'h2);
`else
        chk("fix_order0", {30'b0, order[0]}, 32'h1);
        chk("fix_order1", {30'b0, order[1]}, 32'h1);
        chk("fix_order2", {30'b0, order[2]}, 32'h1);
        chk("fix_order3", {30'b0, order[3]}, 32'h1);
`endif
        cyc();

        // Reset in the middle of a CLR column draw
        clr_x0 = 10'd7; clr_y0 = 9'd0; clr_x1 = 10'd7; clr_y1 = 9'd479;
        req = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cyc();
            seen = pixel_write;
        end
        chk("mid_draw_reached", {31'b0, seen}, 1);
        repeat (10) cyc();
        reset = 1'b1;
        req = 2'b00;
        cyc();
        chk("mid_rst_drw_reset", {31'b0, drw_reset}, 1);
        chk("mid_rst_pixel_write", {31'b0, pixel_write}, 0);
        chk("mid_rst_gnt", {30'b0, gnt}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (done != 2'b00) seen = 1'b1;
        end
        chk("mid_rst_no_done", {31'b0, seen}, 0);
        ani_x0 = 10'd30; ani_y0 = 9'd100; ani_x1 = 10'd100; ani_y1 = 9'd30; ani_color = 1'b1;
        req = 2'b10;
        run_op(1'b1, g, lat_g, lat_w, nrst, nwr, ndone, dbits, saw11, gap);
        chk("post_rst_gnt", {30'b0, g}, 32'h2);
        chk("post_rst_writes", nwr, 73);
        chk("post_rst_done", {30'b0, dbits}, 32'h2);

        // Degenerate line; coordinates change while drawer is held in reset
        ani_x0 = 10'd50; ani_y0 = 9'd50; ani_x1 = 10'd50; ani_y1 = 9'd50; ani_color = 1'b1;
        req = 2'b10;
        cyc(); cyc(); cyc();
        ani_x0 = 10'd200; ani_y0 = 9'd201; ani_x1 = 10'd202; ani_y1 = 9'd203;
        run_op(1'b1, g, lat_g, lat_w, nrst, nwr, ndone, dbits, saw11, gap);
        chk("deg_writes", nwr, 3);
        chk("deg_done", {30'b0, dbits}, 32'h2);
        chk("deg_done_count", ndone, 1);
        chk("deg_drw_x0", {22'b0, drw_x0}, 50);
        chk("deg_drw_x1", {22'b0, drw_x1}, 50);
        chk("deg_drw_y0", {23'b0, drw_y0}, 50);
        chk("deg_drw_y1", {23'b0, drw_y1}, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/line_draw_arbiter.md
Name: line_draw_arbiter

Overview:
- Shares one line_drawer and its VGA_framebuffer write port between two requesters.
  - Requester 0 (CLR) is the screen clearer.
  - Requester 1 (ANI) is the animation generator.
- Per grant, the block latches endpoints and colour, holds the drawer in reset, releases it, and detects completion.
- It then returns a one-cycle done pulse to the granted requester.
- It replaces ad-hoc listen muxing and fixed-count drawer-reset timing.

Parameters:
- RST_CYCLES, 5, cycles drw_reset is held high before each draw (min 1).
- TAIL_CYCLES, 2, extra write cycles after endpoint detected, to flush drawer pipeline (min 0).

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  2  request per requester; bit 0 = CLR, bit 1 = ANI
- clr_x0, clr_x1  in  10 each  CLR endpoints x
- clr_y0, clr_y1  in  9 each  CLR endpoints y
- clr_color  in  1  CLR pixel colour
- ani_x0, ani_x1  in  10 each  ANI endpoints x
- ani_y0, ani_y1  in  9 each  ANI endpoints y
- ani_color  in  1  ANI pixel colour
- gnt  out  2  one-hot grant, high LOAD through DONE
- done  out  2  one-cycle completion pulse to granted requester
- busy  out  1  high whenever state != IDLE
- x, y  in  10 / 9  current drawer output coordinate
- drw_reset  out  1  line_drawer reset
- drw_x0, drw_x1  out  10 each  latched endpoints x to drawer
- drw_y0, drw_y1  out  9 each  latched endpoints y to drawer
- pixel_color  out  1  latched colour to framebuffer
- pixel_write  out  1  framebuffer write enable

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, gnt=0, done=0, busy=0, drw_reset=1, pixel_write=0, pixel_color=0, drw_* = 0, rr pointer=0.
- States: IDLE, LOAD, RST, DRAW, TAIL, DONE.
- IDLE:
  - drw_reset=1, pixel_write=0.
  - If req!=0, grant per priority; fixed priority is CLR > ANI.
  - Go to LOAD; gnt is set in the same edge.
- LOAD (1 cycle):
  - Latch the granted requester's x0/y0/x1/y1/color into drw_*/pixel_color.
  - Go to RST.
- RST:
  - drw_reset=1 for exactly RST_CYCLES cycles, counted by an internal counter.
  - Then go to DRAW with drw_reset=0.
- DRAW:
  - pixel_write=1.
  - When x==drw_x1 && y==drw_y1, go to TAIL, or to DONE if TAIL_CYCLES=0.
  - The endpoint pixel is written in that cycle.
- TAIL: pixel_write=1 for TAIL_CYCLES cycles, then go to DONE.
- DONE (1 cycle):
  - pixel_write=0, drw_reset=1, done[g]=1.
  - Then go to IDLE; gnt is cleared on entry to IDLE.
- Minimum latency from req sampled to first write cycle: 2+RST_CYCLES edges.
- Degenerate line (x0==x1, y0==y1): completes after 1 DRAW cycle.
- Requester must hold req until done.
  - Deasserting req mid-operation does not abort; done still pulses.
  - Coordinate changes after LOAD are ignored.
- Both requests arriving in the same IDLE cycle: the winner is served fully; the loser is granted in the IDLE cycle immediately after DONE.
- Back-to-back same requester with req still high after done: re-granted next IDLE cycle, subject to priority.
- reset mid-operation: immediate return to reset values next edge; no done pulse issued.
- No timeout. A drawer that never reaches its endpoint holds the grant indefinitely; this is a system-level error.

Optional Feature:
- Macro: LINE_ARB_ROUND_ROBIN_EN.
- Defined:
  - Priority alternates between requesters.
  - The rr pointer flips to the non-granted requester on each DONE.
  - Under continuous dual requests, grants go CLR, ANI, CLR, ...
- Undefined: fixed priority, CLR > ANI; ANI may starve while CLR requests continuously.

Test Plan:
- Single ANI request, (30,100)->(100,30), colour 1, RST_CYCLES=5, TAIL_CYCLES=2:
  - gnt=2'b10 one edge after req.
  - drw_reset high exactly 5 cycles.
  - pixel_write high until x=100,y=30 plus 2 cycles.
  - One done[1] pulse; busy low the next cycle.
- Simultaneous req=2'b11, macro off:
  - CLR (x=7, y 0->479, colour 0) served first.
  - ANI granted the cycle after the CLR DONE.
  - Exactly one done pulse each; gnt never 2'b11.
- Macro on, req held at 2'b11 for 4 operations -> grant order CLR, ANI, CLR, ANI.
- Macro off, same stimulus -> CLR, CLR, CLR, CLR.
- reset asserted during DRAW of the CLR column:
  - Next edge: drw_reset=1, pixel_write=0, gnt=0.
  - No done pulse.
  - A new ANI request then completes normally.
- Degenerate line (50,50)->(50,50):
  - Exactly 1+TAIL_CYCLES write cycles.
  - done asserted.
  - ANI coordinates changed during RST do not alter drw_*.
